// File: rtl/bp_me_pkg.sv
// Shared types for the memory-command wormhole arbiter.
package bp_me_pkg;

    // Arbiter lock state: nothing locked, header stalled with frozen pick, or mid-packet.
    typedef enum logic [1:0] {
        e_idle     = 2'd0,
        e_hdr_wait = 2'd1,
        e_body     = 2'd2
    } bp_me_wh_arb_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin pick among requesters; the start pointer advances past an
// explicitly named winner when yumi_i is asserted.
module bsg_arb_round_robin #(
    parameter int num_req_p = 2,
    parameter int id_w_lp   = $clog2(num_req_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [num_req_p-1:0] reqs_i,
    output logic [id_w_lp-1:0]   grant_id_o,
    output logic                 grant_v_o,
    input  logic                 yumi_i,
    input  logic [id_w_lp-1:0]   yumi_id_i
);

    logic [id_w_lp-1:0] ptr_q, ptr_d;

    // First requester at or after the pointer wins; scanning from the far end
    // lets the nearest one overwrite earlier matches.
    always_comb begin
        grant_v_o  = 1'b0;
        grant_id_o = ptr_q;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (reqs_i[idx]) begin
                grant_v_o  = 1'b1;
                grant_id_o = id_w_lp'(idx);
            end
        end
    end

    // Next pointer is one past the retired winner, wrapping to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (yumi_i) begin
            if (yumi_id_i == id_w_lp'(num_req_p - 1)) ptr_d = '0;
            else                                      ptr_d = yumi_id_i + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bp_me_wormhole_mem_cmd_arbiter.sv
// Per-packet round-robin arbiter sharing one wormhole link among several
// flit streams. Pure pass-through: the lock only steers muxes.
module bp_me_wormhole_mem_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_src_p    = 2,
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 4,
    parameter int id_w_lp      = $clog2(num_src_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_src_p-1:0]              src_v_i,
    input  logic [num_src_p*flit_width_p-1:0] src_data_i,
    output logic [num_src_p-1:0]              src_ready_o,
    output logic                              link_v_o,
    output logic [flit_width_p-1:0]           link_data_o,
    input  logic                              link_ready_i,
    output logic [id_w_lp-1:0]                gnt_id_o
);

    bp_me_wh_arb_state_e     state_q, state_d;
    logic [id_w_lp-1:0]      sel_q, sel_d;
    logic [len_width_p-1:0]  rem_q, rem_d;

    logic [flit_width_p-1:0] src_flit [num_src_p];
    logic [id_w_lp-1:0]      rr_id;
    logic                    rr_v;
    logic [id_w_lp-1:0]      cur_id;
    logic                    is_idle;
    logic                    allow;
    logic                    hs;
    logic                    retire;
    logic [len_width_p-1:0]  hdr_len;

    genvar gi;
    generate
        for (gi = 0; gi < num_src_p; gi++) begin : g_src
            assign src_flit[gi]    = src_data_i[gi*flit_width_p +: flit_width_p];
            assign src_ready_o[gi] = reset_n_i & link_ready_i & allow & (cur_id == id_w_lp'(gi));
        end
    endgenerate

    assign is_idle     = (state_q == e_idle);
    assign cur_id      = is_idle ? rr_id : sel_q;
    assign allow       = is_idle ? rr_v : 1'b1;
    assign link_v_o    = reset_n_i & (is_idle ? rr_v : src_v_i[sel_q]);
    assign link_data_o = src_flit[cur_id];
    assign gnt_id_o    = reset_n_i ? cur_id : '0;
    assign hs          = link_v_o & link_ready_i;
    assign hdr_len     = link_data_o[cord_width_p +: len_width_p];
    // A packet retires on a single-flit header or on the last body flit.
    assign retire      = hs & ((state_q == e_body) ? (rem_q == len_width_p'(1))
                                                   : (hdr_len == '0));

    bsg_arb_round_robin #(
        .num_req_p (num_src_p),
        .id_w_lp   (id_w_lp)
    ) u_rr (
        .clk_i      (clk_i),
        .reset_i    (~reset_n_i),
        .reqs_i     (src_v_i),
        .grant_id_o (rr_id),
        .grant_v_o  (rr_v),
        .yumi_i     (retire),
        .yumi_id_i  (cur_id)
    );

    // Lock/unlock decisions driven by header len and body countdown.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        case (state_q)
            e_idle, e_hdr_wait: begin
                if (hs) begin
                    if (hdr_len == '0) begin
                        state_d = e_idle;
                    end else begin
                        state_d = e_body;
                        rem_d   = hdr_len;
                        sel_d   = cur_id;
                    end
                end else if (is_idle && link_v_o) begin
                    state_d = e_hdr_wait;
                    sel_d   = cur_id;
                end
            end
            e_body: begin
                if (hs) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == len_width_p'(1)) state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // State registers; active-low synchronous reset drops any partial packet.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            sel_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
        end
    end

endmodule
